// File: rtl/mdu_seq_ctrl_pkg.sv
// Shared encodings for the MDU sequencer: op codes, FSM states, flag-bus width
// and the helper that derives {EQ,GT,LT,OV} from a final 32-bit result.
package mdu_seq_ctrl_pkg;

  localparam int MDU_D_WIDTH = 4;

  typedef enum logic [2:0] {
    OP_MULLW  = 3'd0,
    OP_MULHW  = 3'd1,
    OP_MULHWU = 3'd2,
    OP_DIVW   = 3'd3,
    OP_DIVWU  = 3'd4
  } mdu_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FAST,
    S_DONE
  } mdu_state_e;

  // d[3]=EQ, d[2]=GT, d[1]=LT, d[0]=OV; compare is signed against zero.
  function automatic logic [MDU_D_WIDTH-1:0] mdu_flags(input logic [31:0] res,
                                                       input logic        ov);
    logic eq;
    logic lt;
    eq = (res == 32'd0);
    lt = res[31];
    return {eq, ~eq & ~lt, lt, ov};
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Restoring radix-2 divide datapath: load takes magnitudes and records the
// quotient sign, step runs one shift-subtract, fix applies the sign on the last step.
module mdu_div_core
  import mdu_seq_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  input  logic        fix,
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] quotient
);

  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] div_q;
  logic        neg_q;

  logic [32:0] rem_sh;
  logic        ge;
  logic [31:0] rem_nxt;
  logic [31:0] quo_nxt;

  always_comb begin
    rem_sh  = {rem_q, quo_q[31]};
    ge      = (rem_sh >= {1'b0, div_q});
    // The true difference is below the divisor, so 32-bit wraparound is exact.
    rem_nxt = ge ? (rem_sh[31:0] - div_q) : rem_sh[31:0];
    quo_nxt = {quo_q[30:0], ge};
    quotient = (fix && neg_q) ? (32'd0 - quo_nxt) : quo_nxt;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      div_q <= '0;
      neg_q <= 1'b0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= (is_signed && a[31]) ? (32'd0 - a) : a;
      div_q <= (is_signed && b[31]) ? (32'd0 - b) : b;
      neg_q <= is_signed && (a[31] ^ b[31]);
    end else if (step) begin
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
    end
  end

endmodule

// File: rtl/mdu_seq_ctrl.sv
// MDU sequencer: accepts one mul/div op at a time, runs a pipelined multiply
// or the iterative divide core, and returns result plus {EQ,GT,LT,OV}.
module mdu_seq_ctrl
  import mdu_seq_ctrl_pkg::*;
#(
  parameter int MUL_LAT  = 3,
  parameter int DIV_ITER = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [2:0]             op,
  input  logic [31:0]            a,
  input  logic [31:0]            b,
  input  logic                   oe,
  input  logic                   flush,
  output logic                   busy,
  output logic                   resp_valid,
  output logic [31:0]            result,
  output logic [MDU_D_WIDTH-1:0] d
);

  mdu_state_e state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [2:0] op_q;
  logic [31:0] a_q, b_q;
  logic oe_q, fast_ov_q;

  logic [31:0] stage_res_q, held_res_q, stage_res_d;
  logic [MDU_D_WIDTH-1:0] stage_d_q, held_d_q;
  logic stage_ov_d, stage_we;
  logic div_load, div_step, div_fix;
  logic [31:0] div_quo;

  logic accept, is_mul, div0, div_ovf, fast;
  logic [63:0] ext_a, ext_b, prod, mul_tap;
  logic [63:0] mul_pipe [MUL_LAT-1];

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = ~req_ready;
  assign accept     = req_valid & req_ready & ~flush;
  assign resp_valid = (state_q == S_DONE) & ~flush;
  assign result     = resp_valid ? stage_res_q : held_res_q;
  assign d          = resp_valid ? stage_d_q : held_d_q;

  always_comb begin
    is_mul  = (op == OP_MULLW) || (op == OP_MULHW) || (op == OP_MULHWU);
    div0    = ((op == OP_DIVW) || (op == OP_DIVWU)) && (b == 32'd0);
    div_ovf = (op == OP_DIVW) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    fast    = div0 || div_ovf || (op > OP_DIVWU);
    ext_a   = (op == OP_MULHWU) ? {32'd0, a} : {{32{a[31]}}, a};
    ext_b   = (op == OP_MULHWU) ? {32'd0, b} : {{32{b[31]}}, b};
    prod    = ext_a * ext_b;
    mul_tap = mul_pipe[MUL_LAT-2];
  end

  // NOTE: pure data pipe with no reset; its contents are only consumed a fixed
  // number of cycles after a write, so reset would cost flops for nothing.
  always_ff @(posedge clk) begin
    mul_pipe[0] <= prod;
    for (int i = 1; i < MUL_LAT - 1; i++) mul_pipe[i] <= mul_pipe[i-1];
  end

  mdu_div_core u_div_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (div_load),
    .step      (div_step),
    .fix       (div_fix),
    .is_signed (op_q == OP_DIVW),
    .a         (a_q),
    .b         (b_q),
    .quotient  (div_quo)
  );

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_load    = 1'b0;
    div_step    = 1'b0;
    div_fix     = 1'b0;
    stage_we    = 1'b0;
    stage_res_d = '0;
    stage_ov_d  = 1'b0;
    unique case (state_q)
      S_IDLE: if (accept) begin
        if (fast) state_d = S_FAST;
        else if (is_mul) begin
          state_d = S_MUL;
          cnt_d   = 6'(MUL_LAT - 2);
        end else begin
          state_d = S_DIV;
          cnt_d   = 6'(DIV_ITER);
        end
      end
      S_MUL: if (cnt_q == 6'd0) begin
        state_d     = S_DONE;
        stage_we    = 1'b1;
        stage_res_d = (op_q == OP_MULLW) ? mul_tap[31:0] : mul_tap[63:32];
        stage_ov_d  = (op_q == OP_MULLW) && oe_q &&
                      !((&mul_tap[63:31]) || !(|mul_tap[63:31]));
      end else cnt_d = cnt_q - 6'd1;
      S_DIV: if (cnt_q == 6'(DIV_ITER)) begin
        div_load = 1'b1;
        cnt_d    = cnt_q - 6'd1;
      end else begin
        div_step = 1'b1;
        if (cnt_q == 6'd0) begin
          div_fix     = 1'b1;
          state_d     = S_DONE;
          stage_we    = 1'b1;
          stage_res_d = div_quo;
        end else cnt_d = cnt_q - 6'd1;
      end
      S_FAST: begin
        state_d    = S_DONE;
        stage_we   = 1'b1;
        stage_ov_d = fast_ov_q;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      stage_we = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      oe_q        <= 1'b0;
      fast_ov_q   <= 1'b0;
      stage_res_q <= '0;
      stage_d_q   <= '0;
      held_res_q  <= '0;
      held_d_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        op_q      <= op;
        a_q       <= a;
        b_q       <= b;
        oe_q      <= oe;
        fast_ov_q <= oe && (div0 || div_ovf);
      end
      if (stage_we) begin
        stage_res_q <= stage_res_d;
        stage_d_q   <= mdu_flags(stage_res_d, stage_ov_d);
      end
      // A flushed DONE never commits, so the visible result stays as it was.
      if (resp_valid) begin
        held_res_q <= stage_res_q;
        held_d_q   <= stage_d_q;
      end
    end
  end

endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// Self-checking bench for mdu_seq_ctrl: directed vector table, multi-cycle
// flush/reset sequences, and random ops against an arithmetic reference model.
module tb_mdu_seq_ctrl;
  import mdu_seq_ctrl_pkg::*;

  localparam int MUL_LAT  = 3;
  localparam int DIV_ITER = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, oe, flush, busy, resp_valid;
  logic [2:0]  op;
  logic [31:0] a, b, result;
  logic [3:0]  d;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_res;
  logic [3:0]  last_d;

  mdu_seq_ctrl #(.MUL_LAT(MUL_LAT), .DIV_ITER(DIV_ITER)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .op(op), .a(a), .b(b), .oe(oe), .flush(flush), .busy(busy),
    .resp_valid(resp_valid), .result(result), .d(d)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        oe;
    int          lat;
    logic [31:0] res;
    logic [3:0]  d;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit / integer arithmetic on the architectural rules.
  function automatic void model(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                                input logic oev, output logic [31:0] res,
                                output logic [3:0] dd, output int lat);
    longint sa, sb, p;
    logic [63:0] pu;
    logic ov;
    int r;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    p  = sa * sb;
    pu = {32'd0, av} * {32'd0, bv};
    ov = 1'b0;
    res = 32'd0;
    lat = 2;
    case (o)
      3'd0: begin res = p[31:0]; ov = oev && (p != longint'($signed(p[31:0]))); lat = MUL_LAT; end
      3'd1: begin res = p[63:32]; lat = MUL_LAT; end
      3'd2: begin res = pu[63:32]; lat = MUL_LAT; end
      3'd3: if (bv == 0 || (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF)) ov = oev;
            else begin res = 32'(int'($signed(av)) / int'($signed(bv))); lat = DIV_ITER + 2; end
      3'd4: if (bv == 0) ov = oev;
            else begin res = av / bv; lat = DIV_ITER + 2; end
      default: ;
    endcase
    r = int'(res);
    dd = {r == 0, r > 0, r < 0, ov};
  endfunction

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input logic oev, input int exp_lat,
                        input logic [31:0] exp_res, input logic [3:0] exp_d, input bit noise);
    int lat;
    int busy_n;
    @(negedge clk);
    check({name, "_ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; op = o; a = av; b = bv; oe = oev; flush = 1'b0;
    @(negedge clk);
    lat = 0;
    busy_n = 0;
    for (int n = 1; n <= 60; n++) begin
      req_valid = noise;
      if (noise) begin op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom; end
      if (busy) busy_n++;
      if (resp_valid) begin lat = n; break; end
      @(negedge clk);
    end
    req_valid = 1'b0;
    check({name, "_lat"}, 64'(lat), 64'(exp_lat));
    check({name, "_res"}, 64'(result), 64'(exp_res));
    check({name, "_d"}, 64'(d), 64'(exp_d));
    check({name, "_busy"}, 64'(busy_n), 64'(exp_lat));
    @(negedge clk);
    check({name, "_post_resp"}, {62'd0, resp_valid, req_ready}, 64'd1);
    check({name, "_hold"}, {28'd0, d, result}, {28'd0, exp_d, exp_res});
    last_res = exp_res;
    last_d   = exp_d;
  endtask

  initial begin
    logic [31:0] mr;
    logic [3:0]  md;
    int ml;
    bit seen;

    rst_n = 1'b1; req_valid = 1'b0; op = '0; a = '0; b = '0; oe = 1'b0; flush = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("reset_state", {25'd0, req_ready, busy, resp_valid, d, result},
          {25'd0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0});
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    last_res = 32'd0; last_d = 4'd0;

    //                op         a             b             oe lat res           {EQ,GT,LT,OV}
    vecs.push_back('{OP_MULLW,  32'd7,        32'hFFFFFFFD, 1, 3,  32'hFFFFFFEB, 4'b0010});
    vecs.push_back('{OP_MULLW,  32'h00010000, 32'h00010000, 1, 3,  32'd0,        4'b1001});
    vecs.push_back('{OP_MULLW,  32'h00010000, 32'h00010000, 0, 3,  32'd0,        4'b1000});
    vecs.push_back('{OP_DIVW,   32'hFFFFFFF9, 32'd2,        0, 34, 32'hFFFFFFFD, 4'b0010});
    vecs.push_back('{OP_DIVW,   32'h80000000, 32'hFFFFFFFF, 1, 2,  32'd0,        4'b1001});
    vecs.push_back('{OP_DIVWU,  32'd5,        32'd0,        0, 2,  32'd0,        4'b1000});
    vecs.push_back('{OP_MULHWU, 32'hFFFFFFFF, 32'd2,        0, 3,  32'd1,        4'b0100});
    vecs.push_back('{OP_DIVW,   32'd100,      32'd7,        1, 34, 32'd14,       4'b0100});
    vecs.push_back('{OP_MULHW,  32'h80000000, 32'h80000000, 1, 3,  32'h40000000, 4'b0100});
    vecs.push_back('{OP_MULHW,  32'hFFFFFFFF, 32'hFFFFFFFF, 1, 3,  32'd0,        4'b1000});
    vecs.push_back('{OP_MULLW,  32'h7FFFFFFF, 32'd2,        1, 3,  32'hFFFFFFFE, 4'b0011});
    vecs.push_back('{OP_DIVWU,  32'hFFFFFFFF, 32'd1,        1, 34, 32'hFFFFFFFF, 4'b0010});
    vecs.push_back('{3'd7,      32'd5,        32'd5,        1, 2,  32'd0,        4'b1000});
    vecs.push_back('{OP_DIVW,   32'd7,        32'hFFFFFFFE, 0, 34, 32'hFFFFFFFD, 4'b0010});
    vecs.push_back('{OP_DIVW,   32'h80000000, 32'hFFFFFFFF, 0, 2,  32'd0,        4'b1000});
    vecs.push_back('{OP_DIVWU,  32'd7,        32'd10,       1, 34, 32'd0,        4'b1000});

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].oe,
             vecs[i].lat, vecs[i].res, vecs[i].d, bit'(i % 2));

    // Flush mid-divide: no response, controller idle next cycle, outputs unchanged.
    @(negedge clk);
    req_valid = 1'b1; op = OP_DIVWU; a = 32'd100; b = 32'd3; oe = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    seen = 1'b0;
    for (int n = 1; n < 10; n++) begin
      if (resp_valid) seen = 1'b1;
      @(negedge clk);
    end
    flush = 1'b1;
    #1 if (resp_valid) seen = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_div_ready", {62'd0, req_ready, busy}, 64'd2);
    for (int n = 0; n < 40; n++) begin
      if (resp_valid) seen = 1'b1;
      @(negedge clk);
    end
    check("flush_div_no_resp", 64'(seen), 64'd0);
    check("flush_div_hold", {28'd0, d, result}, {28'd0, last_d, last_res});
    run_op("mulhwu_after_flush", OP_MULHWU, 32'hFFFFFFFF, 32'd2, 1'b0, 3, 32'd1, 4'b0100, 1'b0);

    // Flush and request in the same idle cycle: nothing is accepted.
    @(negedge clk);
    req_valid = 1'b1; flush = 1'b1; op = OP_MULLW; a = 32'd3; b = 32'd3; oe = 1'b0;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    check("flush_req_idle", {62'd0, req_ready, busy}, 64'd2);
    seen = 1'b0;
    for (int n = 0; n < 6; n++) begin
      if (resp_valid) seen = 1'b1;
      @(negedge clk);
    end
    check("flush_req_no_resp", 64'(seen), 64'd0);

    // Flush in the DONE cycle: response gated off combinationally, result unchanged.
    @(negedge clk);
    req_valid = 1'b1; op = OP_DIVWU; a = 32'd9; b = 32'd0; oe = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("done_before_flush", 64'(resp_valid), 64'd1);
    flush = 1'b1;
    #1;
    check("done_flush_resp", 64'(resp_valid), 64'd0);
    check("done_flush_out", {28'd0, d, result}, {28'd0, last_d, last_res});
    @(negedge clk);
    flush = 1'b0;
    check("done_flush_after", {27'd0, req_ready, d, result}, {27'd0, 1'b1, last_d, last_res});

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    req_valid = 1'b1; op = OP_DIVW; a = 32'd1000; b = 32'd3; oe = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    for (int n = 1; n < 15; n++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midop_reset", {25'd0, req_ready, busy, resp_valid, d, result},
          {25'd0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0});
    @(negedge clk);
    rst_n = 1'b1;
    last_res = 32'd0; last_d = 4'd0;
    run_op("divw_after_reset", OP_DIVW, 32'd100, 32'd7, 1'b0, 34, 32'd14, 4'b0100, 1'b0);

    // Random ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      logic        roe;
      ro  = 3'($urandom_range(0, 7));
      ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      if ($urandom_range(0, 9) == 0) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      roe = 1'($urandom_range(0, 1));
      model(ro, ra, rb, roe, mr, md, ml);
      run_op($sformatf("rand%0d", i), ro, ra, rb, roe, ml, mr, md, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
